// File: rtl/datapath_sequencer.sv
// Micro-sequencer for the register-file/ALU/RAM datapath: turns macro-commands
// into one registered 24-bit control word plus 64-bit K per clock.
module datapath_sequencer #(
  parameter logic [4:0] FS_ADD   = 5'b01000,
  parameter int         MAX_COPY = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_da,
  input  logic [4:0]  cmd_sa,
  input  logic [4:0]  cmd_sb,
  input  logic [4:0]  cmd_fs,
  input  logic        cmd_use_k,
  input  logic [63:0] cmd_k,
  output logic [23:0] controlWord,
  output logic [63:0] K,
  input  logic [3:0]  status,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] OP_ALU   = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;
  localparam logic [1:0] OP_COPY  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    CP_LD = 2'd2,
    CP_ST = 2'd3
  } stateT;

  stateT       stateR, stateNextS;
  logic [1:0]  opR;
  logic [4:0]  daR, saR, sbR;
  logic [8:0]  nR, cntR, cntNextS, cntPlusS, cmdCountS;
  logic [23:0] cwNextS;
  logic [63:0] kNextS;
  logic [3:0]  flagsNextS;
  logic        doneNextS, acceptS;

  function automatic logic [23:0] makeCw(input logic [4:0] da, input logic [4:0] sa,
                                         input logic [4:0] sb, input logic [4:0] fs,
                                         input logic regW, input logic ramW,
                                         input logic selAlu, input logic selK);
    return {da, sa, sb, fs, regW, ramW, selAlu, selK};
  endfunction

  assign cmd_ready = (stateR == IDLE) && reset;
  assign acceptS   = cmd_valid && cmd_ready;
  assign cmdCountS = (cmd_k > 64'(MAX_COPY)) ? 9'(MAX_COPY) : cmd_k[8:0];
  assign cntPlusS  = cntR + 9'd1;

  // Next state and the control word that the next cycle will present.
  always_comb begin
    stateNextS = stateR;
    cwNextS    = 24'd0;
    kNextS     = 64'd0;
    doneNextS  = 1'b0;
    cntNextS   = cntR;
    flagsNextS = flags;
    case (stateR)
      IDLE: begin
        if (acceptS) begin
          case (cmd_op)
            OP_ALU: begin
              stateNextS = EXEC;
              cwNextS    = makeCw(cmd_da, cmd_sa, cmd_sb, cmd_fs, 1'b1, 1'b0, 1'b1, cmd_use_k);
              kNextS     = cmd_use_k ? cmd_k : 64'd0;
              doneNextS  = 1'b1;
            end
            OP_LOAD: begin
              stateNextS = EXEC;
              cwNextS    = makeCw(cmd_da, cmd_sa, 5'd0, FS_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
              kNextS     = cmd_k;
              doneNextS  = 1'b1;
            end
            OP_STORE: begin
              stateNextS = EXEC;
              cwNextS    = makeCw(5'd0, cmd_sa, cmd_sb, FS_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
              kNextS     = cmd_k;
              doneNextS  = 1'b1;
            end
            OP_COPY: begin
              // An empty copy completes in IDLE without issuing any write.
              if (cmdCountS == 9'd0) begin
                doneNextS = 1'b1;
              end else begin
                stateNextS = CP_LD;
                cwNextS    = makeCw(cmd_da, cmd_sa, 5'd0, FS_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
                cntNextS   = 9'd0;
              end
            end
            default: stateNextS = IDLE;
          endcase
        end else begin
          stateNextS = IDLE;
        end
      end
      EXEC: begin
        stateNextS = IDLE;
        if (opR == OP_ALU) begin
          flagsNextS = status;
        end else begin
          flagsNextS = flags;
        end
      end
      CP_LD: begin
        stateNextS = CP_ST;
        cwNextS    = makeCw(5'd0, sbR, daR, FS_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
        kNextS     = {55'd0, cntR};
        doneNextS  = (cntPlusS >= nR);
      end
      CP_ST: begin
        if (cntPlusS < nR) begin
          stateNextS = CP_LD;
          cntNextS   = cntPlusS;
          cwNextS    = makeCw(daR, saR, 5'd0, FS_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
          kNextS     = {55'd0, cntPlusS};
        end else begin
          stateNextS = IDLE;
        end
      end
      default: stateNextS = IDLE;
    endcase
  end

  // State, captured command fields and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateR      <= IDLE;
      opR         <= OP_ALU;
      daR         <= 5'd0;
      saR         <= 5'd0;
      sbR         <= 5'd0;
      nR          <= 9'd0;
      cntR        <= 9'd0;
      controlWord <= 24'd0;
      K           <= 64'd0;
      flags       <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (acceptS) begin
        opR <= cmd_op;
        daR <= cmd_da;
        saR <= cmd_sa;
        sbR <= cmd_sb;
        nR  <= cmdCountS;
      end
      stateR      <= stateNextS;
      cntR        <= cntNextS;
      controlWord <= cwNextS;
      K           <= kNextS;
      flags       <= flagsNextS;
      busy        <= (stateNextS != IDLE);
      done        <= doneNextS;
    end
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Micro-sequencer driving the 24-bit control word and 64-bit K constant of the register-file/ALU/RAM datapath.
- Accepts macro-commands over a valid/ready handshake and issues one or more control words, one per clock.
- Supports single-cycle ALU, LOAD and STORE, plus a multi-cycle block COPY (RAM to RAM through a temp register).
- Latches the ALU status flags from ALU commands.

Parameters:
- FS_ADD, 5'b01000, ALU function-select code for 64-bit add, used for address generation.
- MAX_COPY, 256, maximum COPY word count (RAM depth); larger requests saturate.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  0=ALU, 1=LOAD, 2=STORE, 3=COPY.
- cmd_da  in  5  destination reg (ALU/LOAD); temp reg (COPY).
- cmd_sa  in  5  A-source reg; base address reg (LOAD/STORE); source base (COPY).
- cmd_sb  in  5  B-source reg; store-data reg (STORE); destination base (COPY).
- cmd_fs  in  5  ALU function (ALU op only).
- cmd_use_k  in  1  ALU op: B operand = cmd_k.
- cmd_k  in  64  immediate / address offset / COPY count.
- controlWord  out  24  {DA[23:19], SA[18:14], SB[13:9], FS[8:4], regW[3], ramW[2], selALU[1], selK[0]}.
- K  out  64  constant to datapath.
- status  in  4  live ALU status from datapath.
- flags  out  4  status latched from last ALU command.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse on last control word of a command.

Behaviour:
- All outputs registered. Reset (reset=0, async) forces:
  - controlWord=0 (NOP: regW=ramW=0), K=0, flags=0, busy=0, done=0.
  - State IDLE, copy counter 0.
- cmd_ready = (state==IDLE) && reset deasserted; combinational from state. Accept on rising edge with cmd_valid && cmd_ready.
- States: IDLE, EXEC, CP_LD, CP_ST.
- IDLE: controlWord=0, K=0. On accept, capture all cmd fields.
  - ALU/LOAD/STORE go to EXEC.
  - COPY with count!=0 goes to CP_LD.
  - COPY with count==0 stays IDLE, pulses done in the next cycle, no control word with regW/ramW set.
- EXEC: one cycle, then IDLE with done=1 for that cycle. Control word per op:
  - ALU: DA=da, SA=sa, SB=sb, FS=fs, regW=1, ramW=0, selALU=1, selK=use_k, K=use_k?k:0.
  - LOAD: DA=da, SA=sa, SB=0, FS=FS_ADD, regW=1, ramW=0, selALU=0, selK=1, K=k (R[da]=RAM[R[sa]+k]).
  - STORE: DA=0, SA=sa, SB=sb, FS=FS_ADD, regW=0, ramW=1, selALU=1, selK=1, K=k (RAM[R[sa]+k]=R[sb]).
- ALU op: flags <= status sampled at end of the EXEC cycle. Flags are visible the cycle after done and are unchanged by other ops.
- COPY:
  - N = min(cmd_k, MAX_COPY); 9-bit counter i starts at 0.
  - CP_LD: LOAD word with DA=da, SA=sa, K=i.
  - CP_ST: STORE with SA=sb, SB=da, K=i.
  - CP_LD→CP_ST always. CP_ST→CP_LD with i+1 if i+1<N; else CP_ST→IDLE with done=1 during that final CP_ST cycle.
  - Total 2N cycles. K upper bits are zero-extended from i.
- busy=1 in every non-IDLE state. done asserts only in the final issuing cycle. Never done and cmd_ready in the same cycle, except the COPY N=0 case, where done pulses in IDLE.
- cmd_valid while busy is ignored and held off by cmd_ready=0; the command is not lost if the requester keeps it asserted.
- Reset mid-command: sequence aborts immediately; the next edge issues NOP; partially copied words remain.
- Overlapping registers (da==sa, etc.) are not checked; the datapath semantics apply.

Test Plan:
- Reset: drive reset=0 mid-COPY → controlWord=0, busy=0, done=0, flags=0 immediately; cmd_ready=1 after release.
- ALU imm: op=0, da=3, sa=1, fs=FS_ADD, use_k=1, k=5 → next cycle controlWord={3,1,sb,FS_ADD,1,0,1,1}, K=5, done=1; flags match status next cycle.
- LOAD then STORE back-to-back: LOAD da=2, sa=0, k=16, then STORE sa=0, sb=2, k=17 → one control word each (regW/ramW as specified), cmd_ready low only during EXEC; RAM[17]=RAM[16].
- COPY N=3: sa=4 (base 0), sb=5 (base 100), da=9 → 6 cycles alternating LD/ST with K=0,0,1,1,2,2; done on cycle 6; RAM[100..102]=RAM[0..2].
- COPY N=0 and N=1000: N=0 → done in 1 cycle, no writes; N=1000 → exactly 512 issue cycles, final K=255.
- Hold-off: cmd_valid held high during a COPY → second command accepted the cycle after done, not earlier.
